// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: one outstanding memory request at a time,
// responses land in a small circular queue that feeds decode.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ex_take_branch_out,
  input  logic [XLEN-1:0]              ex_target_PC_out,
  output logic                         proc2Imem_req,
  output logic [XLEN-1:0]              proc2Imem_addr,
  input  logic                         Imem2proc_gnt,
  input  logic                         Imem2proc_rvalid,
  input  logic [31:0]                  Imem2proc_data,
  input  logic                         id_ready,
  output logic                         if_valid_inst_out,
  output logic [XLEN-1:0]              if_PC_out,
  output logic [XLEN-1:0]              if_NPC_out,
  output logic [31:0]                  if_IR_out,
  output logic [$clog2(DEPTH+1)-1:0]   if_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] inflight_pc;
  logic            outstanding;
  logic            stale;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] q_pc [DEPTH];
  logic [31:0]     q_ir [DEPTH];

  logic grant;
  logic resp;
  logic push;
  logic pop;

  always_comb begin
    proc2Imem_req     = ~rst & ~outstanding & (count != FULL) & ~ex_take_branch_out;
    proc2Imem_addr    = {pc_reg[XLEN-1:2], 2'b00};
    grant             = proc2Imem_req & Imem2proc_gnt;
    resp              = Imem2proc_rvalid & outstanding;
    push              = resp & ~stale & ~ex_take_branch_out;
    if_valid_inst_out = ~rst & (count != '0);
    pop               = if_valid_inst_out & id_ready & ~ex_take_branch_out;
    if_count          = count;
    if_PC_out         = '0;
    if_NPC_out        = '0;
    if_IR_out         = '0;
    if (if_valid_inst_out) begin
      if_PC_out  = q_pc[head];
      if_NPC_out = q_pc[head] + XLEN'(4);
      if_IR_out  = q_ir[head];
    end
  end

  // A response that arrives in the redirect cycle itself is consumed and
  // dropped; otherwise the in-flight request is marked stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      inflight_pc <= '0;
      outstanding <= 1'b0;
      stale       <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (ex_take_branch_out) begin
      pc_reg      <= {ex_target_PC_out[XLEN-1:2], 2'b00};
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= outstanding & ~Imem2proc_rvalid;
      stale       <= outstanding & ~Imem2proc_rvalid;
    end else begin
      if (grant) begin
        outstanding <= 1'b1;
        inflight_pc <= pc_reg;
        pc_reg      <= pc_reg + XLEN'(4);
      end
      if (resp) begin
        outstanding <= 1'b0;
        stale       <= 1'b0;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail] <= inflight_pc;
      q_ir[tail] <= Imem2proc_data;
    end
  end

endmodule
